// File: rtl/ics_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ics_pkg
// Purpose  : Shared constants and state encoding for the ICS2115 sample port.
// Revision : 1.0 - initial release
// ============================================================================
package ics_pkg;

  localparam int LINE_BYTES = 8;
  localparam int BEATS      = 4;
  localparam int TAG_W      = 26;
  localparam int WORD_W     = 16;
  localparam int LINE_W     = WORD_W * BEATS;
  localparam int ADDR_W     = 29;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_FILL = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ics_word_rotate.sv
`default_nettype none
// ============================================================================
// Module   : ics_word_rotate
// Purpose  : Rotates a 64-bit line so word idx_i lands in the low 16 bits.
// Revision : 1.0 - initial release
// ============================================================================
module ics_word_rotate
  import ics_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [1:0]        idx_i,
  output logic [LINE_W-1:0] rot_o
);

  genvar i;
  generate
    for (i = 0; i < BEATS; i++) begin : g_word
      logic [1:0] w_sel;
      assign w_sel = idx_i + 2'(i);
      assign rot_o[WORD_W*i +: WORD_W] = line_i[{w_sel, 4'b0000} +: WORD_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ics_sample_port.sv
`default_nettype none
// ============================================================================
// Module   : ics_sample_port
// Purpose  : ICS2115 sample-fetch responder with a single 64-bit line buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ics_sample_port
  import ics_pkg::*;
#(
  parameter logic [TAG_W-1:0] BASE_LINE = 26'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sdram_rd,
  input  logic [ADDR_W-1:0]   sdram_addr,
  output logic [LINE_W-1:0]   sdram_dout,
  output logic                sdram_busy,
  output logic                sdram_dout_ready,
  input  logic                inval,
  output logic                mem_req,
  output logic [TAG_W-1:0]    mem_addr,
  input  logic                mem_ack,
  input  logic                mem_valid,
  input  logic [WORD_W-1:0]   mem_data
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:1]   a_q, a_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                line_valid_q, line_valid_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                inval_pend_q, inval_pend_d;
  logic                mem_req_q, mem_req_d;
  logic [TAG_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   dout_q, dout_d;
  logic                ready_q, ready_d;

  logic                w_beat;
  logic                w_last_beat;
  logic                w_hit;
  logic [1:0]          w_rot_idx;
  logic [LINE_W-1:0]   w_rot_line;
  logic                w_unused_addr_bit;

  assign w_unused_addr_bit = sdram_addr[0];

  assign w_beat      = (state_q == ST_FILL) && mem_valid;
  assign w_last_beat = w_beat && (cnt_q == 2'(BEATS - 1));
  assign w_hit       = line_valid_q && (tag_q == sdram_addr[ADDR_W-1:3]);

  // The final beat is folded in before rotation so RESP can present it at once.
  always_comb begin
    line_d = line_q;
    if (w_beat) begin
      line_d[{cnt_q, 4'b0000} +: WORD_W] = mem_data;
    end
  end

  assign w_rot_idx = (state_q == ST_IDLE) ? sdram_addr[2:1] : a_q[2:1];

  ics_word_rotate u_rotate (
    .line_i (line_d),
    .idx_i  (w_rot_idx),
    .rot_o  (w_rot_line)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    cnt_d        = cnt_q;
    inval_pend_d = inval_pend_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    dout_d       = dout_q;
    ready_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inval) begin
          line_valid_d = 1'b0;
        end
        if (sdram_rd) begin
          a_d = sdram_addr[ADDR_W-1:1];
          if (w_hit) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            dout_d  = w_rot_line;
          end else begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = BASE_LINE + sdram_addr[ADDR_W-1:3];
          end
        end
      end

      ST_REQ: begin
        if (inval) begin
          inval_pend_d = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = 2'd0;
          state_d   = ST_FILL;
        end
      end

      ST_FILL: begin
        if (inval) begin
          inval_pend_d = 1'b1;
        end
        if (w_beat) begin
          cnt_d = cnt_q + 2'd1;
        end
        if (w_last_beat) begin
          tag_d        = a_q[ADDR_W-1:3];
          line_valid_d = !(inval_pend_q || inval);
          inval_pend_d = 1'b0;
          state_d      = ST_RESP;
          ready_d      = 1'b1;
          dout_d       = w_rot_line;
        end
      end

      ST_RESP: begin
        if (inval) begin
          line_valid_d = 1'b0;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      tag_q        <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      cnt_q        <= 2'd0;
      inval_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      dout_q       <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      cnt_q        <= cnt_d;
      inval_pend_q <= inval_pend_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      dout_q       <= dout_d;
      ready_q      <= ready_d;
    end
  end

  assign sdram_dout       = dout_q;
  assign sdram_busy       = (state_q != ST_IDLE);
  assign sdram_dout_ready = ready_q;
  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ics_sample_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_ics_sample_port
// Purpose  : Self-checking bench for ics_sample_port against a line-cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ics_sample_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdram_rd;
  logic [28:0] sdram_addr;
  logic        inval;
  logic        mem_ack;
  logic        mem_valid;
  logic [15:0] mem_data;

  logic [63:0] dout;
  logic        busy;
  logic        ready;
  logic        mreq;
  logic [25:0] maddr;

  logic [63:0] dout_w;
  logic        busy_w;
  logic        ready_w;
  logic        mreq_w;
  logic [25:0] maddr_w;

  int checks = 0;
  int errors = 0;

  // Reference model: one cached line of four words
  bit          m_valid;
  logic [25:0] m_tag;
  logic [15:0] m_line [4];

  localparam logic [25:0] WRAP_BASE = 26'h3FF_FFFF;

  always #5 clk = ~clk;

  ics_sample_port #(.BASE_LINE(26'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .sdram_rd         (sdram_rd),
    .sdram_addr       (sdram_addr),
    .sdram_dout       (dout),
    .sdram_busy       (busy),
    .sdram_dout_ready (ready),
    .inval            (inval),
    .mem_req          (mreq),
    .mem_addr         (maddr),
    .mem_ack          (mem_ack),
    .mem_valid        (mem_valid),
    .mem_data         (mem_data)
  );

  ics_sample_port #(.BASE_LINE(WRAP_BASE)) dut_wrap (
    .clk              (clk),
    .reset            (reset),
    .sdram_rd         (sdram_rd),
    .sdram_addr       (sdram_addr),
    .sdram_dout       (dout_w),
    .sdram_busy       (busy_w),
    .sdram_dout_ready (ready_w),
    .inval            (inval),
    .mem_req          (mreq_w),
    .mem_addr         (maddr_w),
    .mem_ack          (mem_ack),
    .mem_valid        (mem_valid),
    .mem_data         (mem_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rot(input int k);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = m_line[(k + i) % 4];
    return r;
  endfunction

  // One complete request; inv_beat selects the beat (0..3) carrying an inval, -1 for none
  task automatic fetch(input logic [28:0] a, input int ack_dly, input int gap,
                       input int inv_beat, input bit scramble, input bit fixed);
    logic [15:0] d [4];
    bit          hit;
    int          k;
    logic [25:0] tag;
    tag = a[28:3];
    k   = int'(a[2:1]);
    hit = m_valid && (m_tag == tag);
    sdram_addr = a;
    sdram_rd   = 1'b1;
    tick();
    if (hit) begin
      chk("hit_no_req", {63'd0, mreq}, 64'd0);
      chk("hit_ready", {63'd0, ready}, 64'd1);
      chk("hit_dout", dout, rot(k));
    end else begin
      chk("miss_req", {63'd0, mreq}, 64'd1);
      chk("miss_busy", {63'd0, busy}, 64'd1);
      chk("miss_addr", {38'd0, maddr}, {38'd0, tag});
      chk("miss_addr_wrap", {38'd0, maddr_w}, {38'd0, 26'(tag + WRAP_BASE)});
      repeat (ack_dly) begin
        tick();
        chk("req_hold", {63'd0, mreq}, 64'd1);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("ack_drop", {63'd0, mreq}, 64'd0);
      if (scramble) sdram_addr = 29'($urandom);
      for (int b = 0; b < 4; b++) begin
        d[b] = fixed ? 16'(16'h1111 * (b + 1)) : 16'($urandom);
        repeat (gap) begin
          tick();
          chk("gap_no_ready", {63'd0, ready}, 64'd0);
        end
        mem_valid = 1'b1;
        mem_data  = d[b];
        inval     = (b == inv_beat);
        tick();
        mem_valid = 1'b0;
        inval     = 1'b0;
        if (b < 3) chk("fill_no_ready", {63'd0, ready}, 64'd0);
      end
      m_line  = d;
      m_tag   = tag;
      m_valid = (inv_beat < 0);
      chk("miss_ready", {63'd0, ready}, 64'd1);
      chk("miss_dout", dout, rot(k));
    end
    sdram_rd = 1'b0;
    tick();
    chk("done_ready", {63'd0, ready}, 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic pulse_inval();
    inval = 1'b1;
    tick();
    inval = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;
    reset      = 1'b1;
    sdram_rd   = 1'b0;
    sdram_addr = '0;
    inval      = 1'b0;
    mem_ack    = 1'b0;
    mem_valid  = 1'b0;
    mem_data   = '0;
    m_valid    = 1'b0;
    m_tag      = '0;
    for (int i = 0; i < 4; i++) m_line[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_dout", dout, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_mem_req", {63'd0, mreq}, 64'd0);
    chk("rst_mem_addr", {38'd0, maddr}, 64'd0);
    chk("rst_mem_addr_wrap", {38'd0, maddr_w}, 64'd0);

    // Cold miss and hit with rotation
    fetch(29'h0000_0010, 3, 0, -1, 1'b0, 1'b1);
    chk("cold_mem_addr", {38'd0, maddr}, 64'h2);
    chk("cold_dout", dout, 64'h4444_3333_2222_1111);
    held = dout;
    tick();
    chk("dout_hold", dout, held);
    fetch(29'h0000_0014, 0, 0, -1, 1'b0, 1'b0);
    chk("hit_rot_dout", dout, 64'h2222_1111_4444_3333);

    // Wrapping line offset
    fetch(29'h0000_0008, 0, 0, -1, 1'b0, 1'b0);
    chk("wrap_mem_addr", {38'd0, maddr_w}, 64'h0);

    // Invalidate mid-fill, then with the last beat, then in idle
    fetch(29'h0000_0120, 1, 0, 1, 1'b0, 1'b0);
    fetch(29'h0000_0122, 0, 0, 3, 1'b0, 1'b0);
    fetch(29'h0000_0124, 0, 0, -1, 1'b0, 1'b0);
    fetch(29'h0000_0126, 0, 0, -1, 1'b0, 1'b0);
    pulse_inval();
    fetch(29'h0000_0126, 0, 0, -1, 1'b0, 1'b0);

    // Reset after two beats, stray beats afterwards
    pulse_inval();
    sdram_addr = 29'h0ABC_DE40;
    sdram_rd   = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1;
      mem_data  = 16'($urandom);
      tick();
    end
    mem_valid = 1'b0;
    reset     = 1'b1;
    sdram_rd  = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_req", {63'd0, mreq}, 64'd0);
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1'b1;
      mem_data  = 16'($urandom);
      tick();
      chk("stray_no_ready", {63'd0, ready}, 64'd0);
      chk("stray_no_busy", {63'd0, busy}, 64'd0);
    end
    mem_valid = 1'b0;
    m_valid   = 1'b0;
    fetch(29'h0ABC_DE40, 0, 0, -1, 1'b0, 1'b0);

    // Gapped beats with the request address moving during the fill
    pulse_inval();
    fetch(29'h1234_5676, 2, 2, -1, 1'b1, 1'b0);
    fetch(29'h1234_5670, 0, 0, -1, 1'b0, 1'b0);

    // Randomized mix of hits and misses across a few lines
    for (int n = 0; n < 40; n++) begin
      logic [28:0] a;
      a = {26'($urandom_range(0, 3) + 26'h15A), 2'($urandom_range(0, 3)), 1'($urandom)};
      if ($urandom_range(0, 9) == 0) pulse_inval();
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1,
            1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
